// File: rtl/herald_pkg.sv
// Shared definitions for the herald host bridge: command codes, FSM states,
// status bit positions and the raw command length table.
package herald_pkg;

  localparam logic [7:0] CMD_SINCOS    = 8'h10;
  localparam logic [7:0] CMD_ATAN2     = 8'h11;
  localparam logic [7:0] CMD_SQRT      = 8'h12;
  localparam logic [7:0] CMD_NORMALIZE = 8'h13;
  localparam logic [7:0] CMD_MUL       = 8'h20;
  localparam logic [7:0] CMD_MAC       = 8'h21;
  localparam logic [7:0] CMD_CLEAR     = 8'h22;
  localparam logic [7:0] CMD_MSU       = 8'h23;

  localparam int ST_LAST_OK = 0;
  localparam int ST_ABORTED = 1;
  localparam int ST_ILLEGAL = 2;
  localparam int ST_TIMEOUT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPER,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_t;

  typedef struct packed {
    logic       known;
    logic [3:0] n_ops;
    logic [3:0] n_res_words;
  } cmd_info_t;

  // Raw lengths only; limits against the instance parameters are applied by the decoder.
  function automatic cmd_info_t cmd_decode(input logic [7:0] cmd);
    cmd_info_t info;
    info = '0;
    case (cmd)
      CMD_SINCOS:    info = '{1'b1, 4'd1, 4'd2};
      CMD_ATAN2:     info = '{1'b1, 4'd2, 4'd1};
      CMD_SQRT:      info = '{1'b1, 4'd2, 4'd1};
      CMD_NORMALIZE: info = '{1'b1, 4'd2, 4'd3};
      CMD_MUL:       info = '{1'b1, 4'd2, 4'd1};
      CMD_MAC:       info = '{1'b1, 4'd2, 4'd1};
      CMD_CLEAR:     info = '{1'b1, 4'd0, 4'd0};
      CMD_MSU:       info = '{1'b1, 4'd2, 4'd1};
      default:       info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/herald_cmd_decode.sv
// Combinational command decoder: table lookup plus limit check against the
// operand/result capacity of this bridge instance.
module herald_cmd_decode
  import herald_pkg::*;
#(
  parameter int MAX_OPS       = 2,
  parameter int MAX_RES_WORDS = 3
) (
  input  logic [7:0] cmd,
  output logic       legal,
  output logic [3:0] n_ops,
  output logic [3:0] n_res_words
);

  cmd_info_t info;

  assign info        = cmd_decode(cmd);
  assign n_ops       = info.n_ops;
  assign n_res_words = info.n_res_words;
  assign legal       = info.known
                       && (32'(info.n_ops) <= MAX_OPS)
                       && (32'(info.n_res_words) <= MAX_RES_WORDS);

endmodule

// File: rtl/herald_host_bridge.sv
// Byte-serial host bridge: collects a command and its operands, hands them to a
// compute engine over valid/ready, then streams the result back byte by byte.
module herald_host_bridge
  import herald_pkg::*;
#(
  parameter int OP_BYTES      = 3,
  parameter int MAX_OPS       = 2,
  parameter int MAX_RES_WORDS = 3,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          ui_in,
  input  logic                                wr_strb,
  input  logic                                rd_strb,
  input  logic                                abort_strb,
  output logic [7:0]                          uo_out,
  output logic                                busy,
  output logic                                irq,
  output logic [7:0]                          eng_cmd,
  output logic [MAX_OPS*OP_BYTES*8-1:0]       eng_operands,
  output logic                                eng_start_valid,
  input  logic                                eng_start_ready,
  input  logic                                eng_res_valid,
  output logic                                eng_res_ready,
  input  logic [MAX_RES_WORDS*OP_BYTES*8-1:0] eng_res_data,
  output logic                                eng_abort
);

  localparam int OP_BUF_BYTES  = MAX_OPS * OP_BYTES;
  localparam int RES_BUF_BYTES = MAX_RES_WORDS * OP_BYTES;
  localparam int BCW = $clog2(OP_BUF_BYTES + 1);
  localparam int RCW = $clog2(RES_BUF_BYTES + 1);
  localparam int TCW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_t state_reg, state_next;

  logic wr_q_reg, rd_q_reg, abort_q_reg;
  logic wr_edge, rd_edge, abort_edge;

  logic       dec_legal;
  logic [3:0] dec_n_ops, dec_n_res;

  logic [7:0]                   eng_cmd_reg;
  logic [BCW-1:0]               op_len_reg, byte_cnt_reg;
  logic [RCW-1:0]               res_len_reg, rd_cnt_reg;
  logic [TCW-1:0]               tmo_cnt_reg;
  logic [RES_BUF_BYTES*8-1:0]   res_reg;
  logic [3:0]                   status_reg;
  logic [7:0]                   uo_out_reg;
  logic                         eng_abort_reg;

  logic in_eng, tmo_hit;
  logic latch_cmd, set_illegal, status_rd, opnd_we, res_cap, res_rd, host_abort, tmo_abort;

  assign wr_edge    = wr_strb & ~wr_q_reg;
  assign rd_edge    = rd_strb & ~rd_q_reg;
  assign abort_edge = abort_strb & ~abort_q_reg;

  herald_cmd_decode #(
    .MAX_OPS       (MAX_OPS),
    .MAX_RES_WORDS (MAX_RES_WORDS)
  ) u_decode (
    .cmd         (ui_in),
    .legal       (dec_legal),
    .n_ops       (dec_n_ops),
    .n_res_words (dec_n_res)
  );

  assign in_eng  = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt_reg == TCW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      wr_q_reg    <= 1'b0;
      rd_q_reg    <= 1'b0;
      abort_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wr_q_reg    <= wr_strb;
      rd_q_reg    <= rd_strb;
      abort_q_reg <= abort_strb;
    end
  end

  always_comb begin
    state_next  = state_reg;
    latch_cmd   = 1'b0;
    set_illegal = 1'b0;
    status_rd   = 1'b0;
    opnd_we     = 1'b0;
    res_cap     = 1'b0;
    res_rd      = 1'b0;
    host_abort  = 1'b0;
    tmo_abort   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (wr_edge) begin
          if (dec_legal) begin
            latch_cmd  = 1'b1;
            state_next = (dec_n_ops == 4'd0) ? S_ISSUE : S_OPER;
          end else begin
            set_illegal = 1'b1;
          end
        end else if (rd_edge) begin
          status_rd = 1'b1;
        end
      end
      S_OPER: begin
        if (abort_edge) begin
          host_abort = 1'b1;
          state_next = S_IDLE;
        end else if (wr_edge) begin
          opnd_we = 1'b1;
          if (byte_cnt_reg == op_len_reg - 1'b1) state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort_edge) begin
          host_abort = 1'b1;
          state_next = S_IDLE;
        end else if (tmo_hit) begin
          tmo_abort  = 1'b1;
          state_next = S_IDLE;
        end else if (eng_start_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_edge) begin
          host_abort = 1'b1;
          state_next = S_IDLE;
        end else if (tmo_hit) begin
          tmo_abort  = 1'b1;
          state_next = S_IDLE;
        end else if (eng_res_valid) begin
          res_cap    = 1'b1;
          state_next = (res_len_reg != '0) ? S_RESULT : S_IDLE;
        end
      end
      S_RESULT: begin
        if (abort_edge) begin
          host_abort = 1'b1;
          state_next = S_IDLE;
        end else if (rd_edge) begin
          res_rd = 1'b1;
          if (rd_cnt_reg == res_len_reg - 1'b1) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cmd_reg   <= '0;
      op_len_reg    <= '0;
      res_len_reg   <= '0;
      byte_cnt_reg  <= '0;
      rd_cnt_reg    <= '0;
      tmo_cnt_reg   <= '0;
      res_reg       <= '0;
      status_reg    <= '0;
      uo_out_reg    <= '0;
      eng_abort_reg <= 1'b0;
    end else begin
      eng_abort_reg <= 1'b0;
      // Counter sits at zero outside ISSUE/WAIT, so it starts fresh on ISSUE entry.
      if (in_eng && (TIMEOUT_CYC != 0)) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      else                              tmo_cnt_reg <= '0;
      if (latch_cmd) begin
        eng_cmd_reg  <= ui_in;
        op_len_reg   <= BCW'(32'(dec_n_ops) * OP_BYTES);
        res_len_reg  <= RCW'(32'(dec_n_res) * OP_BYTES);
        byte_cnt_reg <= '0;
        rd_cnt_reg   <= '0;
      end
      if (set_illegal) status_reg[ST_ILLEGAL] <= 1'b1;
      if (status_rd) begin
        uo_out_reg                         <= {4'b0000, status_reg};
        status_reg[ST_TIMEOUT:ST_ABORTED]  <= '0;
      end
      if (opnd_we) byte_cnt_reg <= byte_cnt_reg + 1'b1;
      if (res_cap) begin
        res_reg                 <= eng_res_data;
        status_reg[ST_LAST_OK]  <= 1'b1;
        rd_cnt_reg              <= '0;
      end
      if (res_rd) begin
        uo_out_reg <= res_reg[{rd_cnt_reg, 3'b000} +: 8];
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end
      if (host_abort) begin
        byte_cnt_reg            <= '0;
        rd_cnt_reg              <= '0;
        status_reg[ST_ABORTED]  <= 1'b1;
        status_reg[ST_LAST_OK]  <= 1'b0;
        eng_abort_reg           <= in_eng;
      end
      if (tmo_abort) begin
        status_reg[ST_TIMEOUT]  <= 1'b1;
        status_reg[ST_LAST_OK]  <= 1'b0;
        eng_abort_reg           <= 1'b1;
      end
    end
  end

  // One register per operand byte; a new command clears the whole buffer.
  generate
    for (genvar gi = 0; gi < OP_BUF_BYTES; gi++) begin : g_opnd
      logic [7:0] byte_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           byte_reg <= '0;
        else if (latch_cmd)                                byte_reg <= '0;
        else if (opnd_we && (byte_cnt_reg == BCW'(gi)))    byte_reg <= ui_in;
      end
      assign eng_operands[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  assign uo_out          = uo_out_reg;
  assign busy            = (state_reg == S_OPER) || in_eng;
  assign irq             = (state_reg == S_RESULT);
  assign eng_cmd         = eng_cmd_reg;
  assign eng_start_valid = (state_reg == S_ISSUE);
  assign eng_res_ready   = (state_reg == S_WAIT);
  assign eng_abort       = eng_abort_reg;

endmodule

// File: tb/tb_herald_host_bridge.sv
// Directed bench for herald_host_bridge: a table of full command transactions
// plus hand-written sequences for illegal commands, timeout, abort and reset.
module tb_herald_host_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic        wr_strb, rd_strb, abort_strb;
  logic [7:0]  uo_out;
  logic        busy, irq;
  logic [7:0]  eng_cmd;
  logic [47:0] eng_operands;
  logic        eng_start_valid, eng_start_ready;
  logic        eng_res_valid, eng_res_ready;
  logic [71:0] eng_res_data;
  logic        eng_abort;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  herald_host_bridge #(
    .OP_BYTES      (3),
    .MAX_OPS       (2),
    .MAX_RES_WORDS (3),
    .TIMEOUT_CYC   (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ui_in           (ui_in),
    .wr_strb         (wr_strb),
    .rd_strb         (rd_strb),
    .abort_strb      (abort_strb),
    .uo_out          (uo_out),
    .busy            (busy),
    .irq             (irq),
    .eng_cmd         (eng_cmd),
    .eng_operands    (eng_operands),
    .eng_start_valid (eng_start_valid),
    .eng_start_ready (eng_start_ready),
    .eng_res_valid   (eng_res_valid),
    .eng_res_ready   (eng_res_ready),
    .eng_res_data    (eng_res_data),
    .eng_abort       (eng_abort)
  );

  typedef struct {
    logic [7:0]  cmd;
    int          n_op_bytes;
    logic [47:0] op_stream;     // bytes in write order, first byte in LSBs
    logic [47:0] exp_operands;
    logic [71:0] res;
    int          n_rd;
    logic [71:0] exp_rd;        // expected read bytes, first read in LSBs
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic sv);
    ui_in   = b;
    wr_strb = 1'b1;
    @(negedge clk);
    sv      = eng_start_valid;
    wr_strb = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_byte(output logic [7:0] d, output logic irq_s);
    rd_strb = 1'b1;
    @(negedge clk);
    d       = uo_out;
    irq_s   = irq;
    rd_strb = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_abort(output logic ea, output logic bz);
    abort_strb = 1'b1;
    @(negedge clk);
    ea         = eng_abort;
    bz         = busy;
    abort_strb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic        sv, ir, ea, bz;
    logic [7:0]  d;
    logic [47:0] ops;
    logic [71:0] exp_rd;
    int          cnt;

    vecs[0] = '{8'h20, 6, 48'h002000_001000, 48'h002000_001000, 72'h000200, 3, 72'h000200};
    vecs[1] = '{8'h13, 6, 48'h00ABCD_001234, 48'h00ABCD_001234,
                72'h030000_020000_010000, 9, 72'h030000_020000_010000};
    vecs[2] = '{8'h10, 3, 48'h000000_7F0001, 48'h000000_7F0001,
                72'hEEEEEE_654321_ABCDEF, 6, 72'h000000_654321_ABCDEF};
    vecs[3] = '{8'h23, 6, 48'h665544_332211, 48'h665544_332211,
                72'h123456_789ABC_C0FFEE, 3, 72'h000000_000000_C0FFEE};

    rst = 1'b1; ui_in = '0; wr_strb = 0; rd_strb = 0; abort_strb = 0;
    eng_start_ready = 0; eng_res_valid = 0; eng_res_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_uo_out", uo_out, 0);
    check("reset_busy", busy, 0);
    check("reset_start_valid", eng_start_valid, 0);
    check("reset_eng_abort", eng_abort, 0);
    check("reset_irq", irq, 0);
    check("reset_operands", eng_operands, 0);

    // Illegal command stays idle and flags status; the flag clears on read.
    wr_byte(8'h55, sv);
    check("illegal_busy", busy, 0);
    rd_byte(d, ir);
    check("illegal_status", d, 8'h04);
    rd_byte(d, ir);
    check("illegal_status_cleared", d, 8'h00);
    $display("txn illegal cmd 55 done");

    for (int v = 0; v < 4; v++) begin
      ops    = vecs[v].op_stream;
      exp_rd = vecs[v].exp_rd;
      wr_byte(vecs[v].cmd, sv);
      check("cmd_busy", busy, 1);
      check("cmd_latched", eng_cmd, vecs[v].cmd);
      for (int j = 0; j < vecs[v].n_op_bytes; j++) begin
        wr_byte(ops[8*j +: 8], sv);
        if (j == vecs[v].n_op_bytes - 1) check("start_latency", sv, 1);
        else                             check("no_early_start", sv, 0);
      end
      check("operands", eng_operands, vecs[v].exp_operands);
      repeat (2) @(negedge clk);
      check("start_held", eng_start_valid, 1);
      eng_start_ready = 1'b1;
      @(negedge clk);
      eng_start_ready = 1'b0;
      check("wait_res_ready", eng_res_ready, 1);
      check("wait_start_dropped", eng_start_valid, 0);
      eng_res_data  = vecs[v].res;
      eng_res_valid = 1'b1;
      @(negedge clk);
      eng_res_valid = 1'b0;
      check("irq_latency", irq, 1);
      for (int i = 0; i < vecs[v].n_rd; i++) begin
        rd_byte(d, ir);
        check("result_byte", d, exp_rd[8*i +: 8]);
        check("irq_during_read", ir, (i != vecs[v].n_rd - 1) ? 1 : 0);
      end
      rd_byte(d, ir);
      check("status_ok", d, 8'h01);
      $display("txn cmd %02h: %0d operand bytes, %0d result bytes", vecs[v].cmd,
               vecs[v].n_op_bytes, vecs[v].n_rd);
    end

    // Engine never answers: forced abort exactly 16 cycles after ISSUE entry.
    ui_in = 8'h22; wr_strb = 1'b1;
    @(negedge clk);
    wr_strb = 1'b0;
    check("timeout_issue_entry", eng_start_valid, 1);
    cnt = 0;
    while (cnt <= 40 && eng_abort !== 1'b1) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles", cnt, 16);
    check("timeout_idle", busy, 0);
    @(negedge clk);
    check("timeout_pulse_width", eng_abort, 0);
    rd_byte(d, ir);
    check("timeout_status", d, 8'h08);
    $display("txn timeout after %0d cycles", cnt);

    // Host abort during operand collection.
    wr_byte(8'h21, sv);
    wr_byte(8'h01, sv);
    wr_byte(8'h02, sv);
    do_abort(ea, bz);
    check("abort_oper_busy", bz, 0);
    check("abort_oper_no_eng_abort", ea, 0);
    rd_byte(d, ir);
    check("abort_status", d, 8'h02);
    $display("txn abort during operands");

    // Zero-operand, zero-result command returns straight to idle.
    wr_byte(8'h22, sv);
    check("clear_start", sv, 1);
    eng_start_ready = 1'b1;
    @(negedge clk);
    eng_start_ready = 1'b0;
    check("clear_wait", eng_res_ready, 1);
    eng_res_valid = 1'b1;
    @(negedge clk);
    eng_res_valid = 1'b0;
    check("clear_idle_busy", busy, 0);
    check("clear_no_irq", irq, 0);
    rd_byte(d, ir);
    check("clear_status", d, 8'h01);
    $display("txn clear cmd 22 done");

    // Host abort while the engine owns the operation.
    wr_byte(8'h22, sv);
    eng_start_ready = 1'b1;
    @(negedge clk);
    eng_start_ready = 1'b0;
    do_abort(ea, bz);
    check("abort_wait_eng_abort", ea, 1);
    check("abort_wait_busy", bz, 0);
    check("abort_wait_pulse_end", eng_abort, 0);
    rd_byte(d, ir);
    check("abort_wait_status", d, 8'h02);
    $display("txn abort during wait");

    // Asynchronous reset drops start_valid without waiting for a clock.
    wr_byte(8'h22, sv);
    check("rst_pre_start", eng_start_valid, 1);
    #1 rst = 1'b1;
    #1 check("rst_async_start", eng_start_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_async_busy", busy, 0);
    check("rst_async_cmd", eng_cmd, 0);
    $display("txn async reset mid-issue");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
